// File: rtl/usb_pkg.sv
// rtl/usb_pkg.sv - shared PID codes, SYNC byte and TX sequencer state type
package usb_pkg;

    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    // Sent LSB first, so the line sees 0000_0001
    localparam logic [7:0] SYNC_BYTE = 8'h80;

    // Width of the EOP / idle-J bit-period counter
    localparam int BITCNT_W = 4;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_SYNC,
        TX_PID,
        TX_DATA,
        TX_EOP,
        TX_IDLE_J,
        TX_DONE
    } tx_state_t;

    function automatic logic is_data_pid(input logic [3:0] pid);
        return (pid == PID_DATA0) || (pid == PID_DATA1);
    endfunction

    function automatic logic is_hs_pid(input logic [3:0] pid);
        return (pid == PID_ACK) || (pid == PID_NAK) || (pid == PID_STALL);
    endfunction

endpackage

// File: rtl/usb_tx_bitcnt.sv
// rtl/usb_tx_bitcnt.sv - bit-period down-counter shared by EOP and idle-J
module usb_tx_bitcnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         bit_strobe,
    output logic         zero
);

    logic [W-1:0] cnt;

    // Load wins over decrement; decrement saturates at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (bit_strobe && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/usb_tx_ctrl.sv
// rtl/usb_tx_ctrl.sv - USB full-speed TX packet sequencer (SYNC, PID, payload, EOP, idle-J)
module usb_tx_ctrl
    import usb_pkg::*;
#(
    parameter int MAX_DATA  = 64,
    parameter int EOP_BITS  = 2,
    parameter int IDLE_BITS = 1,
    localparam int CNT_W    = $clog2(MAX_DATA + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tx_start,
    input  logic [3:0]       tx_pid,
    input  logic [CNT_W-1:0] buffer_occupancy,
    input  logic [7:0]       tx_data,
    input  logic             bit_strobe,
    input  logic             byte_complete,
    output logic             enable_timer,
    output logic             load_byte,
    output logic [7:0]       tx_byte,
    output logic             get_tx_data,
    output logic             tx_eop,
    output logic             tx_drive_j,
    output logic             tx_busy,
    output logic             tx_done,
    output logic             tx_error
);

    localparam logic [CNT_W-1:0]    MAX_CNT   = CNT_W'(MAX_DATA);
    // Bit counter holds "strobes remaining minus one" so the zero flag marks the last strobe
    localparam logic [BITCNT_W-1:0] EOP_LOAD  = BITCNT_W'(EOP_BITS - 1);
    localparam logic [BITCNT_W-1:0] IDLE_LOAD = BITCNT_W'(IDLE_BITS - 1);

    tx_state_t           state, state_d;
    logic [3:0]          pid_q;
    logic [CNT_W-1:0]    byte_cnt;
    logic                sync_first;
    logic                err_q, err_d;
    logic                accept;
    logic                bc_load, bc_zero;
    logic [BITCNT_W-1:0] bc_val;

    usb_tx_bitcnt #(.W(BITCNT_W)) u_bitcnt (
        .clk        (clk),
        .rst        (rst),
        .load       (bc_load),
        .load_val   (bc_val),
        .bit_strobe (bit_strobe),
        .zero       (bc_zero)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= TX_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // PID/count latch, payload countdown, SYNC-entry flag and registered error pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            pid_q      <= '0;
            byte_cnt   <= '0;
            sync_first <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            sync_first <= accept;
            err_q      <= err_d;
            if (accept) begin
                pid_q    <= tx_pid;
                byte_cnt <= is_data_pid(tx_pid) ? buffer_occupancy : '0;
            end else if (get_tx_data) begin
                byte_cnt <= byte_cnt - 1'b1;
            end
        end
    end

    // Next state, byte loads/pops on byte_complete, and bit-counter reloads
    always_comb begin
        state_d     = state;
        load_byte   = 1'b0;
        tx_byte     = 8'h00;
        get_tx_data = 1'b0;
        err_d       = 1'b0;
        accept      = 1'b0;
        bc_load     = 1'b0;
        bc_val      = EOP_LOAD;
        case (state)
            TX_IDLE: begin
                if (tx_start) begin
                    if (!is_data_pid(tx_pid) && !is_hs_pid(tx_pid)) begin
                        err_d = 1'b1;
                    end else if (is_data_pid(tx_pid) && (buffer_occupancy > MAX_CNT)) begin
                        err_d = 1'b1;
                    end else begin
                        accept  = 1'b1;
                        state_d = TX_SYNC;
                    end
                end
            end
            TX_SYNC: begin
                if (sync_first) begin
                    load_byte = 1'b1;
                    tx_byte   = SYNC_BYTE;
                end else if (byte_complete) begin
                    load_byte = 1'b1;
                    tx_byte   = {~pid_q, pid_q};
                    state_d   = TX_PID;
                end
            end
            TX_PID: begin
                if (byte_complete) begin
                    if (byte_cnt != '0) begin
                        load_byte   = 1'b1;
                        get_tx_data = 1'b1;
                        tx_byte     = tx_data;
                        state_d     = TX_DATA;
                    end else begin
                        bc_load = 1'b1;
                        state_d = TX_EOP;
                    end
                end
            end
            TX_DATA: begin
                if (byte_complete) begin
                    if (byte_cnt == '0) begin
                        bc_load = 1'b1;
                        state_d = TX_EOP;
                    end else if (buffer_occupancy == '0) begin
                        // FIFO underrun: abort the payload but still close the packet
                        err_d   = 1'b1;
                        bc_load = 1'b1;
                        state_d = TX_EOP;
                    end else begin
                        load_byte   = 1'b1;
                        get_tx_data = 1'b1;
                        tx_byte     = tx_data;
                    end
                end
            end
            TX_EOP: begin
                if (bit_strobe && bc_zero) begin
                    bc_load = 1'b1;
                    bc_val  = IDLE_LOAD;
                    state_d = TX_IDLE_J;
                end
            end
            TX_IDLE_J: begin
                if (bit_strobe && bc_zero) begin
                    state_d = TX_DONE;
                end
            end
            TX_DONE: begin
                state_d = TX_IDLE;
            end
            default: begin
                state_d = TX_IDLE;
            end
        endcase
    end

    assign enable_timer = (state == TX_SYNC) || (state == TX_PID) || (state == TX_DATA) ||
                          (state == TX_EOP)  || (state == TX_IDLE_J);
    assign tx_busy      = (state != TX_IDLE) && (state != TX_DONE);
    assign tx_eop       = (state == TX_EOP);
    assign tx_drive_j   = (state == TX_IDLE_J);
    assign tx_done      = (state == TX_DONE);
    assign tx_error     = err_q;

endmodule

// File: tb/tb_usb_tx_ctrl.sv
// tb/tb_usb_tx_ctrl.sv - directed self-checking bench for usb_tx_ctrl
module tb_usb_tx_ctrl;

    logic       clk;
    logic       rst;
    logic       tx_start;
    logic [3:0] tx_pid;
    logic [6:0] buffer_occupancy;
    logic [7:0] tx_data;
    logic       bit_strobe;
    logic       byte_complete;
    logic       enable_timer;
    logic       load_byte;
    logic [7:0] tx_byte;
    logic       get_tx_data;
    logic       tx_eop;
    logic       tx_drive_j;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_error;

    usb_tx_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .tx_start         (tx_start),
        .tx_pid           (tx_pid),
        .buffer_occupancy (buffer_occupancy),
        .tx_data          (tx_data),
        .bit_strobe       (bit_strobe),
        .byte_complete    (byte_complete),
        .enable_timer     (enable_timer),
        .load_byte        (load_byte),
        .tx_byte          (tx_byte),
        .get_tx_data      (get_tx_data),
        .tx_eop           (tx_eop),
        .tx_drive_j       (tx_drive_j),
        .tx_busy          (tx_busy),
        .tx_done          (tx_done),
        .tx_error         (tx_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // Timer model: bit period = 2 clocks, byte = 16 clocks, cleared while enable_timer is low
    int tcnt = 0;
    int k;
    int occ_force;
    logic [7:0] fifo[$];

    int   load_k[$];
    logic [7:0] load_v[$];
    int   pop_k[$];
    int   eop_n, j_n, done_n, done_k, err_n, err_k, busy_n;

    int exp_lk[$];
    int exp_lv[$];
    int exp_pk[$];

    task automatic chk(input string tag, input int obs, input int exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        logic pop, en;
        @(negedge clk);
        bit_strobe       = enable_timer && (tcnt % 2 == 1);
        byte_complete    = enable_timer && (tcnt % 16 == 15);
        buffer_occupancy = (occ_force >= 0) ? 7'(occ_force) : 7'(fifo.size());
        tx_data          = (fifo.size() > 0) ? fifo[0] : 8'h00;
        #1;
        if (load_byte) begin
            load_k.push_back(k);
            load_v.push_back(tx_byte);
        end
        if (get_tx_data) pop_k.push_back(k);
        if (tx_eop) eop_n++;
        if (tx_drive_j) j_n++;
        if (tx_busy) busy_n++;
        if (tx_done) begin done_n++; done_k = k; end
        if (tx_error) begin err_n++; err_k = k; end
        pop = get_tx_data;
        en  = enable_timer;
        @(posedge clk);
        if (rst || !en) tcnt = 0; else tcnt++;
        if (pop && fifo.size() > 0) void'(fifo.pop_front());
        k++;
        #1;
    endtask

    // Request at k=0; optional second request and reset at given cycle indices
    task automatic run(input logic [3:0] pid, input int occ0, input int budget,
                       input int extra_start, input int rst_at);
        load_k.delete(); load_v.delete(); pop_k.delete();
        eop_n = 0; j_n = 0; done_n = 0; done_k = -1; err_n = 0; err_k = -1; busy_n = 0;
        k = 0;
        for (int i = 0; i < budget; i++) begin
            tx_start  = (k == 0) || (k == extra_start);
            tx_pid    = (k == 0) ? pid : 4'b0011;
            occ_force = (k == 0) ? occ0 : -1;
            rst       = (k == rst_at);
            cycle();
            if (done_n > 0 && k > done_k + 1) break;
        end
        tx_start  = 1'b0;
        occ_force = -1;
    endtask

    task automatic check_logs(input string name, input int eop, input int j, input int dn,
                              input int dk, input int en, input int ek, input int busy);
        chk({name, " load count"}, load_k.size(), exp_lk.size());
        foreach (exp_lk[i]) begin
            chk($sformatf("%s load%0d cycle", name, i), (i < load_k.size()) ? load_k[i] : -1, exp_lk[i]);
            chk($sformatf("%s load%0d byte", name, i), (i < load_v.size()) ? int'(load_v[i]) : -1, exp_lv[i]);
        end
        chk({name, " pop count"}, pop_k.size(), exp_pk.size());
        foreach (exp_pk[i]) begin
            chk($sformatf("%s pop%0d cycle", name, i), (i < pop_k.size()) ? pop_k[i] : -1, exp_pk[i]);
        end
        chk({name, " eop cycles"}, eop_n, eop);
        chk({name, " j cycles"}, j_n, j);
        chk({name, " done count"}, done_n, dn);
        chk({name, " done cycle"}, done_k, dk);
        chk({name, " error count"}, err_n, en);
        chk({name, " error cycle"}, err_k, ek);
        chk({name, " busy cycles"}, busy_n, busy);
    endtask

    function automatic int outs();
        return int'({enable_timer, load_byte, tx_byte, get_tx_data, tx_eop,
                     tx_drive_j, tx_busy, tx_done, tx_error});
    endfunction

    initial begin
        rst = 1'b1; tx_start = 1'b0; tx_pid = 4'h0; buffer_occupancy = '0; tx_data = '0;
        bit_strobe = 1'b0; byte_complete = 1'b0; occ_force = -1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset outputs", outs(), 0);
        rst = 1'b0;

        // ACK handshake
        exp_lk = '{1, 16}; exp_lv = '{8'h80, 8'hD2}; exp_pk.delete();
        run(4'b0010, -1, 200, -1, -1);
        check_logs("ack", 4, 2, 1, 39, 0, -1, 38);

        // DATA0 with three queued bytes
        fifo = '{8'hA5, 8'h3C, 8'hFF};
        exp_lk = '{1, 16, 32, 48, 64}; exp_lv = '{8'h80, 8'hC3, 8'hA5, 8'h3C, 8'hFF};
        exp_pk = '{32, 48, 64};
        run(4'b0011, -1, 300, -1, -1);
        check_logs("data0", 4, 2, 1, 87, 0, -1, 86);

        // Illegal PID
        exp_lk.delete(); exp_lv.delete(); exp_pk.delete();
        run(4'b0000, 0, 5, -1, -1);
        check_logs("badpid", 0, 0, 0, -1, 1, 1, 0);

        // DATA1 announced with 4 bytes, only 2 present: underrun at third payload slot
        fifo = '{8'h11, 8'h22};
        exp_lk = '{1, 16, 32, 48}; exp_lv = '{8'h80, 8'h4B, 8'h11, 8'h22}; exp_pk = '{32, 48};
        run(4'b1011, 4, 300, -1, -1);
        check_logs("underrun", 4, 2, 1, 71, 1, 65, 70);

        // Reset in the middle of the payload
        fifo = '{8'hA5, 8'h3C, 8'hFF};
        run(4'b0011, -1, 41, -1, 40);
        chk("pre-reset loads", load_k.size(), 3);
        chk("pre-reset pops", pop_k.size(), 1);
        chk("post-reset outputs", outs(), 0);
        rst = 1'b0;
        fifo.delete();
        exp_lk = '{1, 16}; exp_lv = '{8'h80, 8'hD2}; exp_pk.delete();
        run(4'b0010, -1, 200, -1, -1);
        check_logs("ack after reset", 4, 2, 1, 39, 0, -1, 38);

        // Second request while busy is ignored
        run(4'b0010, -1, 200, 10, -1);
        check_logs("ack busy start", 4, 2, 1, 39, 0, -1, 38);

        // Oversize DATA0 request rejected immediately
        exp_lk.delete(); exp_lv.delete(); exp_pk.delete();
        run(4'b0011, 65, 5, -1, -1);
        check_logs("oversize", 0, 0, 0, -1, 1, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
